// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Widths, the NOP encoding, the default reset PC and the fixed buffer depth live here.
package if_fetch_pkg;

   localparam int unsigned PC_SIZE    = 32;
   localparam int unsigned INSTR_SIZE = 32;
   localparam int unsigned BUF_DEPTH  = 2;

   typedef logic [PC_SIZE-1:0]    pc_t;
   typedef logic [INSTR_SIZE-1:0] instr_t;

   localparam instr_t INSTR_NOP    = 32'h0000_0013;
   localparam pc_t    DEF_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      pc_t    pc;
      instr_t instr;
   } fetch_entry_t;

   function automatic pc_t pc_seq(input pc_t pc);
      return pc + PC_SIZE'(4);
   endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response plus the predecode/ID and EX side.
// master = fetch stage, slave = surrounding pipeline and memory.
interface if_fetch_if;
   import if_fetch_pkg::*;

   logic   imem_req_valid;
   logic   imem_req_ready;
   pc_t    imem_req_addr;
   logic   imem_rsp_valid;
   instr_t imem_rsp_data;
   logic   out_valid;
   instr_t out_instr;
   pc_t    out_pc;
   logic   id_ready;
   pc_t    pc_next;
   logic   flush;
   pc_t    flush_pc;

   modport master (
      output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready, pc_next, flush, flush_pc
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready, pc_next, flush, flush_pc
   );

endinterface

// File: rtl/if_fetch_buf.sv
// Two-entry synchronous FIFO with clear, occupancy count and combinational head.
// Used both for the {pc,instr} instruction buffer and the outstanding-request PC tag queue.
module if_fetch_buf
   import if_fetch_pkg::*;
#(
   parameter int unsigned     WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_clear,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_head,
   output logic [1:0]       o_count
);

   logic [WIDTH-1:0] r_mem [BUF_DEPTH];
   logic             r_rd_ptr;
   logic             r_wr_ptr;
   logic [1:0]       r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= RESET_VAL;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (i_clear) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (i_pop) r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(i_push && !i_pop && !i_clear && r_count == 2'(BUF_DEPTH)));
   a_no_underflow: assert property (@(posedge clk) disable iff (rst)
      !(i_pop && !i_clear && r_count == 2'd0));

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: sequential prefetch with a 2-entry buffer, predecode-driven
// redirect and EX flush; responses already in flight at a redirect are counted and dropped.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter pc_t RESET_PC = DEF_RESET_PC
) (
   input logic        clk,
   input logic        rst,
   if_fetch_if.master io_bus
);

   localparam fetch_entry_t BUF_RESET = '{pc: RESET_PC, instr: INSTR_NOP};

   pc_t          r_fetch_pc;
   logic [1:0]   r_drop_cnt;

   fetch_entry_t w_head;
   fetch_entry_t w_push_entry;
   pc_t          w_tag_head;
   logic [1:0]   w_buf_cnt;
   logic [1:0]   w_outstanding;
   logic [2:0]   w_credit_sum;
   logic         w_hs;
   logic         w_rsp;
   logic         w_drop_rsp;
   logic         w_accept;
   logic         w_pd_redir;
   logic         w_redir;
   pc_t          w_target;
   logic         w_push_buf;
   logic         w_pop_buf;

   // Issue credit uses only registered counts; a pop this cycle frees space next cycle.
   assign w_credit_sum          = {1'b0, w_buf_cnt} + {1'b0, w_outstanding};
   assign io_bus.imem_req_valid = ~rst & (w_credit_sum < 3'(BUF_DEPTH));
   assign io_bus.imem_req_addr  = r_fetch_pc;
   assign w_hs                  = io_bus.imem_req_valid & io_bus.imem_req_ready;

   // A response with nothing outstanding is a leftover from before reset.
   assign w_rsp      = io_bus.imem_rsp_valid & (w_outstanding != 2'd0);
   assign w_drop_rsp = w_rsp & (r_drop_cnt != 2'd0);

   assign io_bus.out_valid = (w_buf_cnt != 2'd0);
   assign io_bus.out_instr = w_head.instr;
   assign io_bus.out_pc    = w_head.pc;

   assign w_accept   = io_bus.out_valid & io_bus.id_ready;
   assign w_pd_redir = w_accept & (io_bus.pc_next != pc_seq(w_head.pc));
   assign w_redir    = io_bus.flush | w_pd_redir;
   assign w_target   = io_bus.flush ? io_bus.flush_pc : io_bus.pc_next;

   assign w_push_entry = '{pc: w_tag_head, instr: io_bus.imem_rsp_data};
   assign w_push_buf   = w_rsp & ~w_drop_rsp & ~w_redir;
   assign w_pop_buf    = w_accept & ~w_redir;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
         r_drop_cnt <= 2'd0;
      end else if (w_redir) begin
         r_fetch_pc <= w_target;
         // Everything still in flight after this edge belongs to the abandoned path.
         r_drop_cnt <= w_outstanding + {1'b0, w_hs} - {1'b0, w_rsp};
      end else begin
         if (w_hs) r_fetch_pc <= pc_seq(r_fetch_pc);
         if (w_drop_rsp) r_drop_cnt <= r_drop_cnt - 2'd1;
      end
   end

   if_fetch_buf #(
      .WIDTH     ($bits(fetch_entry_t)),
      .RESET_VAL (BUF_RESET)
   ) u_instr_buf (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push_buf),
      .i_pop   (w_pop_buf),
      .i_clear (w_redir),
      .i_data  (w_push_entry),
      .o_head  (w_head),
      .o_count (w_buf_cnt)
   );

   // Tag queue occupancy is the outstanding-request count.
   if_fetch_buf #(
      .WIDTH     (PC_SIZE),
      .RESET_VAL (RESET_PC)
   ) u_tag_q (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_hs),
      .i_pop   (w_rsp),
      .i_clear (1'b0),
      .i_data  (r_fetch_pc),
      .o_head  (w_tag_head),
      .o_count (w_outstanding)
   );

   a_credit: assert property (@(posedge clk) disable iff (rst)
      w_credit_sum <= 3'(BUF_DEPTH));
   a_drop_le_outstanding: assert property (@(posedge clk) disable iff (rst)
      r_drop_cnt <= w_outstanding);

endmodule
